md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MUL_LAT, default 5, meaning busy cycles for mult/multu/msub (legal range 1..15).
REQ-002 SHALL have parameter DIV_LAT, default 10, meaning busy cycles for div/divu (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: op-issue strobe from EX stage, sampled each rising edge.
REQ-006 SHALL have port md_op, input, 3 bits: operation code, qualified by start.
- 000 mult, 001 multu, 010 div, 011 divu.
- 100 mthi, 101 mtlo, 110 msub; 111 reserved.
REQ-007 SHALL have port a, input, 32 bits: rs operand.
REQ-008 SHALL have port b, input, 32 bits: rt operand.
REQ-009 SHALL have port busy, output, 1 bit: high while an operation is in flight.
REQ-010 SHALL have port hi, output, 32 bits: HI register contents.
REQ-011 SHALL have port lo, output, 32 bits: LO register contents.

Function
REQ-012 SHALL implement a state machine with states IDLE, MUL, DIV and a 4-bit down-counter cnt.
REQ-013 SHALL, in IDLE with start=1 and md_op in {000,001,110}: latch a, b and md_op; load cnt=MUL_LAT-1; enter MUL.
REQ-014 SHALL, in IDLE with start=1 and md_op in {010,011}: latch a, b and md_op; load cnt=DIV_LAT-1; enter DIV.
REQ-015 SHALL, in IDLE with start=1 and md_op=100/101: write a into hi/lo at that edge, stay IDLE, keep busy low.
REQ-016 SHALL treat start with md_op=111 as a no-op, with no state or register change.
REQ-017 SHALL drive busy=1 exactly when state is not IDLE, i.e. from the edge after start for MUL_LAT or DIV_LAT cycles.
REQ-018 SHALL decrement cnt each cycle in MUL/DIV; when cnt=0, SHALL write hi/lo at that edge and return to IDLE.
- Result is visible in the same cycle busy falls.
REQ-019 SHALL leave hi/lo unchanged during MUL/DIV until the completing edge.
REQ-020 SHALL ignore start (any md_op, including mthi/mtlo) while busy=1; the issuing pipeline stalls instead.
REQ-021 SHALL compute mult as the signed 64-bit product a*b and multu as the unsigned product; {hi,lo} = product.
REQ-022 SHALL compute msub as {hi,lo} = {hi,lo} - signed(a*b), modulo 2^64, using hi/lo as they stand at the completing edge.
REQ-023 SHALL compute div with truncation toward zero: lo = quotient, hi = remainder with the dividend's sign.
- divu is the unsigned equivalent.
REQ-024 SHALL, for div with a=0x80000000 and b=0xFFFFFFFF, produce lo=0x80000000 and hi=0x00000000 with no other effect.
REQ-025 SHALL, for div/divu with b=0, still occupy DIV_LAT busy cycles and leave hi/lo unchanged.
REQ-026 SHALL use only the latched operands; changes on a, b or md_op during busy SHALL NOT affect the result.
REQ-027 SHALL accept a new start in the same cycle busy falls (back-to-back issue), with no idle gap required.

Reset
REQ-028 SHALL, on reset=1 at any time (including mid-operation), immediately set state=IDLE, cnt=0, busy=0, hi=0, lo=0, and clear latched operands.
REQ-029 SHALL discard any in-flight operation on reset; hi/lo SHALL NOT receive its result after reset releases.

Verification
REQ-030 Scenario: mult, a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 Scenario: multu, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles, hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 Scenario: div, a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Repeat with divu, b=0: hi/lo keep their prior values.
REQ-033 Scenario: mthi a=0x12345678, then mtlo a=0x00000010, then msub a=4, b=4 -> hi=0x12345678, lo=0x00000000 after 5 busy cycles.
REQ-034 Scenario: issue mult, then pulse start with mthi and changed a/b mid-busy -> both ignored; the mult result is as for the original operands.
REQ-035 Scenario: assert reset at busy cycle 3 of a div -> busy=0, hi=lo=0 immediately; after release, values stay 0 with no late write.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO result registers.
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-high reset
//   start, md_op    - op-issue strobe and opcode (mult/multu/div/divu/mthi/mtlo/msub)
//   a, b            - rs / rt operands, latched at issue
//   busy            - high while a multiply or divide is in flight
//   hi, lo          - HI / LO register contents
module md_unit #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 4;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MSUB  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;

    logic            is_mul_c;
    logic            is_div_c;
    logic [2*W-1:0]  a_ext;
    logic [2*W-1:0]  b_ext;
    logic [2*W-1:0]  prod;
    logic [2*W-1:0]  mul_res;
    logic            div_signed;
    logic            a_neg;
    logic            b_neg;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic [W-1:0]    quo_mag;
    logic [W-1:0]    rem_mag;
    logic [W-1:0]    quo;
    logic [W-1:0]    rem;

    // Opcode decode for issue
    assign is_mul_c = (md_op == OP_MULT) || (md_op == OP_MULTU) || (md_op == OP_MSUB);
    assign is_div_c = (md_op == OP_DIV)  || (md_op == OP_DIVU);

    // State register; busy is registered alongside it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
        end
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start && is_mul_c)      state_nx = MUL;
                else if (start && is_div_c) state_nx = DIV;
            end
            MUL, DIV: begin
                if (cnt == '0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Multiply: 64-bit product of extended operands gives signed or unsigned result mod 2^64
    always_comb begin
        a_ext   = (op_q == OP_MULTU) ? {{W{1'b0}}, a_q} : {{W{a_q[W-1]}}, a_q};
        b_ext   = (op_q == OP_MULTU) ? {{W{1'b0}}, b_q} : {{W{b_q[W-1]}}, b_q};
        prod    = a_ext * b_ext;
        mul_res = (op_q == OP_MSUB) ? ({hi, lo} - prod) : prod;
    end

    // Divide on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN with zero remainder
    always_comb begin
        div_signed = (op_q == OP_DIV);
        a_neg      = div_signed && a_q[W-1];
        b_neg      = div_signed && b_q[W-1];
        a_mag      = a_neg ? (~a_q + W'(1)) : a_q;
        b_mag      = b_neg ? (~b_q + W'(1)) : b_q;
        quo_mag    = (b_mag != '0) ? (a_mag / b_mag) : '0;
        rem_mag    = (b_mag != '0) ? (a_mag % b_mag) : '0;
        quo        = (a_neg ^ b_neg) ? (~quo_mag + W'(1)) : quo_mag;
        rem        = a_neg ? (~rem_mag + W'(1)) : rem_mag;
    end

    // Operand latch, countdown and HI/LO update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul_c) begin
                            op_q <= md_op;
                            a_q  <= a;
                            b_q  <= b;
                            cnt  <= CW'(MUL_LAT - 1);
                        end else if (is_div_c) begin
                            op_q <= md_op;
                            a_q  <= a;
                            b_q  <= b;
                            cnt  <= CW'(DIV_LAT - 1);
                        end else if (md_op == OP_MTHI) begin
                            hi <= a;
                        end else if (md_op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                MUL: begin
                    if (cnt == '0) begin
                        {hi, lo} <= mul_res;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DIV: begin
                    if (cnt == '0) begin
                        // Divide by zero burns the cycles but leaves HI/LO alone
                        if (b_q != '0) begin
                            hi <= rem;
                            lo <= quo;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit (default latencies 5 / 10).
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests;
    int fails;

    md_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one start pulse; caller is at a negedge, returns at the next negedge
    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        md_op = op;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count negedges on which busy is still high, bounded
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        md_op = 3'b000;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi got=%h exp=00000000", hi); end
        tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo got=%h exp=00000000", lo); end
    endtask

    task automatic test_mult();
        int n;
        issue(3'b000, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        tests++; if (n !== 5) begin fails++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
        tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        tests++; if (lo !== 32'hFFFF_FFFA) begin fails++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
    endtask

    task automatic test_multu();
        int n;
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        tests++; if (n !== 5) begin fails++; $display("FAIL multu_busy_cycles got=%0d exp=5", n); end
        tests++; if (hi !== 32'hFFFF_FFFE) begin fails++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
        tests++; if (lo !== 32'h0000_0001) begin fails++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
    endtask

    task automatic test_div();
        int n;
        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        tests++; if (n !== 10) begin fails++; $display("FAIL div_busy_cycles got=%0d exp=10", n); end
        tests++; if (lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
        tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
        // divu by zero: full latency, HI/LO untouched
        issue(3'b011, 32'd5, 32'd0);
        wait_idle(n);
        tests++; if (n !== 10) begin fails++; $display("FAIL divz_busy_cycles got=%0d exp=10", n); end
        tests++; if (lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL divz_lo got=%h exp=fffffffd", lo); end
        tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divz_hi got=%h exp=ffffffff", hi); end
        // positive dividend, negative divisor
        issue(3'b010, 32'd7, 32'hFFFF_FFFE);
        wait_idle(n);
        tests++; if (lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_pn_lo got=%h exp=fffffffd", lo); end
        tests++; if (hi !== 32'h0000_0001) begin fails++; $display("FAIL div_pn_hi got=%h exp=00000001", hi); end
        // unsigned divide
        issue(3'b011, 32'd100, 32'd7);
        wait_idle(n);
        tests++; if (lo !== 32'd14) begin fails++; $display("FAIL divu_lo got=%h exp=0000000e", lo); end
        tests++; if (hi !== 32'd2) begin fails++; $display("FAIL divu_hi got=%h exp=00000002", hi); end
        // signed overflow corner
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        tests++; if (lo !== 32'h8000_0000) begin fails++; $display("FAIL divovf_lo got=%h exp=80000000", lo); end
        tests++; if (hi !== 32'h0000_0000) begin fails++; $display("FAIL divovf_hi got=%h exp=00000000", hi); end
    endtask

    task automatic test_msub();
        int n;
        issue(3'b100, 32'h1234_5678, 32'hAAAA_AAAA);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mthi_busy got=%b exp=0", busy); end
        tests++; if (hi !== 32'h1234_5678) begin fails++; $display("FAIL mthi_hi got=%h exp=12345678", hi); end
        issue(3'b101, 32'h0000_0010, 32'h0);
        tests++; if (lo !== 32'h0000_0010) begin fails++; $display("FAIL mtlo_lo got=%h exp=00000010", lo); end
        issue(3'b110, 32'd4, 32'd4);
        wait_idle(n);
        tests++; if (n !== 5) begin fails++; $display("FAIL msub_busy_cycles got=%0d exp=5", n); end
        tests++; if (hi !== 32'h1234_5678) begin fails++; $display("FAIL msub_hi got=%h exp=12345678", hi); end
        tests++; if (lo !== 32'h0000_0000) begin fails++; $display("FAIL msub_lo got=%h exp=00000000", lo); end
    endtask

    task automatic test_reserved();
        issue(3'b111, 32'hDEAD_BEEF, 32'h1);
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rsvd_busy got=%b exp=0", busy); end
        tests++; if (hi !== 32'h1234_5678) begin fails++; $display("FAIL rsvd_hi got=%h exp=12345678", hi); end
        tests++; if (lo !== 32'h0000_0000) begin fails++; $display("FAIL rsvd_lo got=%h exp=00000000", lo); end
    endtask

    task automatic test_ignore_busy();
        int n;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        repeat (2) @(negedge clk);
        // mthi plus new operands while busy: must be dropped
        start = 1'b1;
        md_op = 3'b100;
        a     = 32'h0BAD_F00D;
        b     = 32'h0000_0055;
        @(negedge clk);
        start = 1'b0;
        a     = 32'h1111_1111;
        md_op = 3'b011;
        tests++; if (hi !== 32'h1234_5678) begin fails++; $display("FAIL ign_midbusy_hi got=%h exp=12345678", hi); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ign_midbusy_busy got=%b exp=1", busy); end
        wait_idle(n);
        tests++; if (n !== 2) begin fails++; $display("FAIL ign_remaining_cycles got=%0d exp=2", n); end
        tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL ign_hi got=%h exp=ffffffff", hi); end
        tests++; if (lo !== 32'hFFFF_FFEB) begin fails++; $display("FAIL ign_lo got=%h exp=ffffffeb", lo); end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(3'b000, 32'd3, 32'd5);
        wait_idle(n);
        tests++; if (lo !== 32'd15) begin fails++; $display("FAIL b2b_first_lo got=%h exp=0000000f", lo); end
        // issue in the very cycle busy dropped
        issue(3'b110, 32'd2, 32'd10);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
        wait_idle(n);
        tests++; if (n !== 5) begin fails++; $display("FAIL b2b_busy_cycles got=%0d exp=5", n); end
        tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL b2b_hi got=%h exp=ffffffff", hi); end
        tests++; if (lo !== 32'hFFFF_FFFB) begin fails++; $display("FAIL b2b_lo got=%h exp=fffffffb", lo); end
    endtask

    task automatic test_reset_mid();
        int n;
        issue(3'b100, 32'h0000_AAAA, 32'h0);
        issue(3'b101, 32'h0000_BBBB, 32'h0);
        issue(3'b010, 32'd100, 32'd3);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL rstmid_hi got=%h exp=00000000", hi); end
        tests++; if (lo !== 32'h0) begin fails++; $display("FAIL rstmid_lo got=%h exp=00000000", lo); end
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        wait_idle(n);
        tests++; if (n !== 0) begin fails++; $display("FAIL rstmid_late_busy got=%0d exp=0", n); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL rstmid_late_hi got=%h exp=00000000", hi); end
        tests++; if (lo !== 32'h0) begin fails++; $display("FAIL rstmid_late_lo got=%h exp=00000000", lo); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_msub();
        test_reserved();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
